// File: rtl/iq_mag_sq.sv
// Iterative I^2+Q^2 magnitude-squared stage; accept at edge N gives dout_valid after edge N+IQ_W.
// One sample in flight; the result is held in DONE for as long as dout_ready stays low.
module iq_mag_sq #(
    parameter int IQ_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IQ_W-1:0]       din_i,
    input  logic [IQ_W-1:0]       din_q,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [2*IQ_W-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int DOUT_W = 2 * IQ_W;
    localparam int CNT_W  = (IQ_W > 1) ? $clog2(IQ_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IQ_W-1:0]     r_a;
    logic [IQ_W-1:0]     r_b;
    logic [DOUT_W-1:0]   r_acc;
    logic [DOUT_W-1:0]   r_dout;
    logic                r_dout_valid;
    logic                r_din_ready;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_release;
    logic                w_last;
    logic [IQ_W-1:0]     w_abs_i;
    logic [IQ_W-1:0]     w_abs_q;
    logic [DOUT_W-1:0]   w_pa;
    logic [DOUT_W-1:0]   w_pb;
    logic [DOUT_W-1:0]   w_acc_nxt;

    assign w_accept  = din_valid & r_din_ready;
    assign w_release = r_dout_valid & dout_ready;
    assign w_last    = (r_cnt == CNT_W'(IQ_W - 1));

    // Negating the most negative value wraps to 2^(IQ_W-1), which is correct as unsigned.
    assign w_abs_i = din_i[IQ_W-1] ? (~din_i + 1'b1) : din_i;
    assign w_abs_q = din_q[IQ_W-1] ? (~din_q + 1'b1) : din_q;

    assign w_pa      = r_a[r_cnt] ? ({{IQ_W{1'b0}}, r_a} << r_cnt) : '0;
    assign w_pb      = r_b[r_cnt] ? ({{IQ_W{1'b0}}, r_b} << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_pa + w_pb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_din_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a         <= w_abs_i;
                        r_b         <= w_abs_q;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_din_ready <= 1'b0;
                    end else begin
                        r_din_ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_dout       <= w_acc_nxt;
                        r_dout_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_release) begin
                        r_dout_valid <= 1'b0;
                        r_din_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                    r_din_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = r_din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_iq_mag_sq.sv
// Directed-vector bench for iq_mag_sq: latency, result values, backpressure and mid-calc reset.
module tb_iq_mag_sq;

    localparam int IQ_W = 16;

    logic               clk;
    logic               rst;
    logic [IQ_W-1:0]    din_i;
    logic [IQ_W-1:0]    din_q;
    logic               din_valid;
    logic               din_ready;
    logic [2*IQ_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;

    int checks;
    int errors;

    iq_mag_sq #(.IQ_W(IQ_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic [31:0]        exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic run_sample(input logic [15:0] vi, input logic [15:0] vq,
                              input logic [31:0] vexp, input string nm);
        int t;
        t = 0;
        while (din_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check({nm, "_rdy_wait"}, {63'd0, din_ready}, 64'd1);
        din_i     = vi;
        din_q     = vq;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (IQ_W - 1) @(posedge clk);
        #1;
        check({nm, "_early_vld"}, {63'd0, dout_valid}, 64'd0);
        check({nm, "_busy_rdy"}, {63'd0, din_ready}, 64'd0);
        @(posedge clk); #1;
        check({nm, "_vld"}, {63'd0, dout_valid}, 64'd1);
        check({nm, "_dout"}, {32'd0, dout}, {32'd0, vexp});
        @(posedge clk); #1;
        check({nm, "_vld_clr"}, {63'd0, dout_valid}, 64'd0);
        check({nm, "_rdy_back"}, {63'd0, din_ready}, 64'd1);
        check({nm, "_dout_hold"}, {32'd0, dout}, {32'd0, vexp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ri;
        logic [15:0] rq;
        longint      mi;
        longint      mq;
        logic [31:0] rexp;

        checks = 0;
        errors = 0;

        vecs[0] = '{i:  16'sd3,      q:  16'sd4,      exp: 32'd25};
        vecs[1] = '{i: -16'sd32768,  q: -16'sd32768,  exp: 32'h8000_0000};
        vecs[2] = '{i:  16'sd0,      q:  16'sd0,      exp: 32'd0};
        vecs[3] = '{i:  16'sd32767,  q: -16'sd1,      exp: 32'h3FFF_0002};
        vecs[4] = '{i: -16'sd1,      q:  16'sd1,      exp: 32'd2};
        vecs[5] = '{i:  16'sd5,      q:  16'sd12,     exp: 32'd169};
        vecs[6] = '{i: -16'sd7,      q:  16'sd0,      exp: 32'd49};
        vecs[7] = '{i:  16'sd100,    q: -16'sd200,    exp: 32'd50000};
        vecs[8] = '{i: -16'sd32768,  q:  16'sd32767,  exp: 32'h7FFF_0001};

        rst        = 1'b0;
        din_i      = '0;
        din_q      = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", {63'd0, din_ready}, 64'd0);
        check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
        check("rst_dout", {32'd0, dout}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_din_ready", {63'd0, din_ready}, 64'd1);

        for (int n = 0; n < 9; n++) begin
            run_sample(vecs[n].i, vecs[n].q, vecs[n].exp, $sformatf("vec%0d", n));
        end

        // Backpressure in DONE: result must hold while new input is ignored.
        dout_ready = 1'b0;
        run_sample_bp: begin
            din_i = 16'd3; din_q = 16'd4; din_valid = 1'b1;
            @(posedge clk); #1;
            din_i = 16'd1000; din_q = 16'd2000;
            repeat (IQ_W) @(posedge clk);
            #1;
            check("bp_vld", {63'd0, dout_valid}, 64'd1);
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                check($sformatf("bp_dout_c%0d", c), {32'd0, dout}, 64'd25);
                check($sformatf("bp_vld_c%0d", c), {63'd0, dout_valid}, 64'd1);
                check($sformatf("bp_rdy_c%0d", c), {63'd0, din_ready}, 64'd0);
            end
            din_valid  = 1'b0;
            dout_ready = 1'b1;
            @(posedge clk); #1;
            check("bp_rel_vld", {63'd0, dout_valid}, 64'd0);
            check("bp_rel_rdy", {63'd0, din_ready}, 64'd1);
            check("bp_rel_dout", {32'd0, dout}, 64'd25);
            repeat (IQ_W + 2) @(posedge clk);
            #1;
            check("bp_no_capture_vld", {63'd0, dout_valid}, 64'd0);
            check("bp_no_capture_rdy", {63'd0, din_ready}, 64'd1);
        end

        // Reset pulse on CALC step k=5 drops the in-flight sample.
        din_i = 16'd100; din_q = 16'd100; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_vld", {63'd0, dout_valid}, 64'd0);
        check("midrst_rdy", {63'd0, din_ready}, 64'd0);
        check("midrst_dout", {32'd0, dout}, 64'd0);
        @(posedge clk); #1;
        check("midrst_rel_rdy", {63'd0, din_ready}, 64'd1);
        repeat (IQ_W) @(posedge clk);
        #1;
        check("midrst_no_result", {63'd0, dout_valid}, 64'd0);
        run_sample(16'd5, 16'd12, 32'd169, "post_rst");

        for (int n = 0; n < 8; n++) begin
            ri = 16'($urandom);
            rq = 16'($urandom);
            mi = longint'($signed(ri));
            mq = longint'($signed(rq));
            rexp = 32'(mi * mi + mq * mq);
            run_sample(ri, rq, rexp, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
